store_bus_adapter: RTL
======================

Name: store_bus_adapter

Overview:
- Sits directly downstream of the store unit's commit-queue port.
- Takes one committed physical store at a time (addr/size/data), aligns it onto a 64-bit data bus with byte enables, and runs a request/grant plus response transaction.
- Returns a held ack/err (plus bus read data for AMO) until the store unit consumes it.
- Misaligned stores are rejected locally without any bus access.

Parameters:
- TIMEOUT_CYCLES, 256, cycles in WAIT_RSP before a forced error (used only with the optional feature).
- BUS_DW, 64, bus data width in bits; fixed at 64 in this version.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock domain; reset is synchronous and active-low
- flush_i  in  1  abandon an unissued request
- d_store_req_i  in  1  store request; held until acked
- d_store_i  in  phy_store_t  {addr 64, size 2, data 64}; stable while req is high
- d_store_ack_o  out  1  store done; held until taken
- d_store_err_o  out  1  qualifies ack; access or alignment error
- d_store_data_o  out  64  bus rdata captured at response (AMO old value; 0 for plain stores)
- d_store_ack_ready_i  in  1  store unit consumes the ack this cycle (tied to store_result_ready)
- bus_req_o  out  1  bus request
- bus_gnt_i  in  1  bus grant
- bus_addr_o  out  64  8-byte-aligned address
- bus_we_o  out  1  always 1 while requesting
- bus_be_o  out  8  byte enables
- bus_wdata_o  out  64  lane-shifted data
- bus_rvalid_i  in  1  response valid
- bus_err_i  in  1  response error
- bus_rdata_i  in  64  response data

Behaviour:
- States: IDLE, REQ, WAIT_RSP, RESP.
- Reset values: state=IDLE; bus_req_o=0, bus_be_o=0, bus_addr_o=0, bus_wdata_o=0; d_store_ack_o=0, d_store_err_o=0, d_store_data_o=0.
- Outputs are registered, with one exception: bus_req_o is high in REQ only.
- IDLE, when d_store_req_i=1:
  - Capture addr, size and data.
  - Alignment check: size=1 needs addr[0]=0; size=2 needs addr[1:0]=0; size=3 needs addr[2:0]=0.
  - Misaligned → RESP with err=1 and data=0. No bus activity.
  - Aligned → REQ.
- Bus fields:
  - bus_addr_o = {addr[63:3],3'b0}.
  - bus_be_o = (size 0: 8'h01, size 1: 8'h03, size 2: 8'h0F, size 3: 8'hFF) << addr[2:0].
  - bus_wdata_o = data << (addr[2:0]*8), truncated to 64 bits.
- REQ: hold bus_req_o and all bus fields stable until bus_gnt_i=1, then go to WAIT_RSP.
- WAIT_RSP:
  - On bus_rvalid_i: capture err=bus_err_i and data=bus_rdata_i, go to RESP.
  - bus_rvalid_i in the same cycle as the grant is ignored. The response is earliest the cycle after grant.
- RESP:
  - ack=1 held, with err and data held.
  - When d_store_ack_ready_i=1, go to IDLE and deassert ack the next cycle.
  - A new d_store_req_i is not sampled in the cycle ack is taken. It is sampled from the following cycle, because the store unit's request and data then reflect the next entry.
- Minimum latency, aligned store with immediate grant and next-cycle rvalid: req seen at cycle 0 → bus_req_o at cycle 1 → ack at cycle 3.
- flush_i:
  - In IDLE or REQ: go to IDLE and drop bus_req_o (committed stores are normally not flushed; this is for safety).
  - In WAIT_RSP or RESP: ignored. A granted write must complete and report.
- Reset mid-transaction: immediately to IDLE on the next edge. No ack is generated.
- d_store_req_i dropping while in REQ or WAIT_RSP is a protocol violation; an assertion flags it.

Optional Feature:
- Macro STORE_BUS_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entering WAIT_RSP and increments each cycle there.
  - Reaching TIMEOUT_CYCLES → RESP with err=1, data=0.
  - A late bus_rvalid_i while in IDLE, REQ or RESP is dropped.
- Undefined: no counter; WAIT_RSP waits indefinitely.

Decomposition:
- tortoise_pkg: phy_store_t (existing) and a new store_bus_state_e enum.
- riscv_pkg: add the BYTE/HALF/WORD/DWORD size encoding constants if not already present.
- One sub-module, store_lane_align: combinational addr/size/data → be/wdata/misaligned. Keeps the FSM file clean and is unit-testable alone.

Test Plan:
- Byte store, addr=0x1005, data=0xAB, size=0, grant same cycle, rvalid next cycle → bus_addr=0x1000, be=8'h20, wdata=0x0000AB0000000000; ack=1, err=0 at cycle 3.
- Word store, addr=0x2002, size=2 (misaligned) → no bus_req_o; ack=1, err=1 on cycle 1; held until d_store_ack_ready_i.
- Dword store, addr=0x3000, grant delayed 5 cycles, rvalid with bus_err_i=1 → bus fields stable throughout REQ; ack with err=1.
- d_store_ack_ready_i held low 4 cycles after ack → ack, err and data stay constant; next req is sampled only after ack is taken; two back-to-back stores produce exactly two bus transactions.
- AMO-style response with bus_rdata_i=0xDEADBEEF → d_store_data_o=0xDEADBEEF while ack is high; reset asserted in WAIT_RSP → all outputs 0 next cycle and no ack.
- With STORE_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, no rvalid → ack with err=1 exactly 8 cycles after entering WAIT_RSP.

Source files
------------

// File: rtl/store_bus_adapter_pkg.sv
// ============================================================================
// Module      : store_bus_adapter_pkg
// Description : Shared types, size encodings and byte-mask helper for the
//               store bus adapter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_bus_adapter_pkg;

  localparam logic [1:0] c_size_byte  = 2'd0;
  localparam logic [1:0] c_size_half  = 2'd1;
  localparam logic [1:0] c_size_word  = 2'd2;
  localparam logic [1:0] c_size_dword = 2'd3;

  typedef struct packed {
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
  } phy_store_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESP     = 2'd3
  } store_bus_state_e;

  function automatic logic [7:0] size_to_mask(input logic [1:0] size);
    case (size)
      c_size_byte: return 8'h01;
      c_size_half: return 8'h03;
      c_size_word: return 8'h0F;
      default:     return 8'hFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_bus_adapter_lane_align.sv
// ============================================================================
// Module      : store_bus_adapter_lane_align
// Description : Combinational lane placement of a store onto the 64-bit bus:
//               byte enables, shifted write data and alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_bus_adapter_lane_align
  import store_bus_adapter_pkg::*;
(
  input  logic [2:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic [63:0] i_data,
  output logic [7:0]  o_be,
  output logic [63:0] o_wdata,
  output logic        o_misaligned
);

  assign o_be    = size_to_mask(i_size) << i_offset;
  assign o_wdata = i_data << {i_offset, 3'b000};

  always_comb begin
    o_misaligned = 1'b0;
    case (i_size)
      c_size_half:  o_misaligned = i_offset[0];
      c_size_word:  o_misaligned = |i_offset[1:0];
      c_size_dword: o_misaligned = |i_offset;
      default:      o_misaligned = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_bus_adapter.sv
// ============================================================================
// Module      : store_bus_adapter
// Description : Adapts committed physical stores onto a 64-bit req/gnt bus
//               and returns a held ack/err/data. Optional response timeout
//               is enabled by defining STORE_BUS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_bus_adapter
  import store_bus_adapter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int BUS_DW         = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              d_store_req_i,
  input  phy_store_t        d_store_i,
  output logic              d_store_ack_o,
  output logic              d_store_err_o,
  output logic [BUS_DW-1:0] d_store_data_o,
  input  logic              d_store_ack_ready_i,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic [63:0]       bus_addr_o,
  output logic              bus_we_o,
  output logic [7:0]        bus_be_o,
  output logic [BUS_DW-1:0] bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic              bus_err_i,
  input  logic [BUS_DW-1:0] bus_rdata_i
);

  if (TIMEOUT_CYCLES < 1 || BUS_DW != 64) begin : g_param_check
    $error("store_bus_adapter: unsupported TIMEOUT_CYCLES or BUS_DW");
  end

  store_bus_state_e  r_state, w_state_next;
  logic [63:0]       r_bus_addr, w_bus_addr_next;
  logic [7:0]        r_bus_be, w_bus_be_next;
  logic [BUS_DW-1:0] r_bus_wdata, w_bus_wdata_next;
  logic              r_ack, w_ack_next;
  logic              r_err, w_err_next;
  logic [BUS_DW-1:0] r_data, w_data_next;
  logic [7:0]        w_be;
  logic [63:0]       w_wdata;
  logic              w_misaligned;

`ifdef STORE_BUS_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_cnt_w-1:0] r_cnt, w_cnt_next;
`endif

  store_bus_adapter_lane_align u_lane_align (
    .i_offset     (d_store_i.addr[2:0]),
    .i_size       (d_store_i.size),
    .i_data       (d_store_i.data),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned)
  );

  always_comb begin
    w_state_next     = r_state;
    w_bus_addr_next  = r_bus_addr;
    w_bus_be_next    = r_bus_be;
    w_bus_wdata_next = r_bus_wdata;
    w_ack_next       = r_ack;
    w_err_next       = r_err;
    w_data_next      = r_data;
`ifdef STORE_BUS_TIMEOUT_EN
    w_cnt_next       = r_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (d_store_req_i && !flush_i) begin
          if (w_misaligned) begin
            // Rejected locally: report straight away, bus fields untouched.
            w_state_next = ST_RESP;
            w_ack_next   = 1'b1;
            w_err_next   = 1'b1;
            w_data_next  = '0;
          end else begin
            w_state_next     = ST_REQ;
            w_bus_addr_next  = {d_store_i.addr[63:3], 3'b000};
            w_bus_be_next    = w_be;
            w_bus_wdata_next = w_wdata;
          end
        end
      end
      ST_REQ: begin
        if (flush_i) begin
          w_state_next = ST_IDLE;
        end else if (bus_gnt_i) begin
          w_state_next = ST_WAIT_RSP;
`ifdef STORE_BUS_TIMEOUT_EN
          w_cnt_next   = '0;
`endif
        end
      end
      ST_WAIT_RSP: begin
        if (bus_rvalid_i) begin
          w_state_next = ST_RESP;
          w_ack_next   = 1'b1;
          w_err_next   = bus_err_i;
          w_data_next  = bus_rdata_i;
        end
`ifdef STORE_BUS_TIMEOUT_EN
        else if (r_cnt + 1'b1 == c_cnt_w'(TIMEOUT_CYCLES)) begin
          w_state_next = ST_RESP;
          w_ack_next   = 1'b1;
          w_err_next   = 1'b1;
          w_data_next  = '0;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        if (d_store_ack_ready_i) begin
          w_state_next = ST_IDLE;
          w_ack_next   = 1'b0;
          w_err_next   = 1'b0;
          w_data_next  = '0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_data      <= '0;
`ifdef STORE_BUS_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_bus_addr  <= w_bus_addr_next;
      r_bus_be    <= w_bus_be_next;
      r_bus_wdata <= w_bus_wdata_next;
      r_ack       <= w_ack_next;
      r_err       <= w_err_next;
      r_data      <= w_data_next;
`ifdef STORE_BUS_TIMEOUT_EN
      r_cnt       <= w_cnt_next;
`endif
    end
  end

  assign bus_req_o      = (r_state == ST_REQ);
  assign bus_we_o       = (r_state == ST_REQ);
  assign bus_addr_o     = r_bus_addr;
  assign bus_be_o       = r_bus_be;
  assign bus_wdata_o    = r_bus_wdata;
  assign d_store_ack_o  = r_ack;
  assign d_store_err_o  = r_err;
  assign d_store_data_o = r_data;

`ifndef SYNTHESIS
  // The store unit must keep its request up until the transaction reports.
  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == ST_REQ || r_state == ST_WAIT_RSP) |-> d_store_req_i);
`endif

endmodule

`default_nettype wire
